fifo_serial_tx: RTL and testbench

- Reader-side companion to the team's synchronous FIFO: pops words through the FIFO's rd_en/empty/data_out interface and serialises each word onto a single line.
- Frame format: start bit, N data bits LSB-first, optional parity bit, stop bit.
- Sits between the FIFO read port and an off-block serial pin; this block is the FIFO's only reader.

---
 rtl/fifo_tx_pkg.sv | 17 +
 rtl/bit_timer.sv | 32 +++
 rtl/fifo_serial_tx.sv | 175 +++++++++++++++++
 tb/tb_fifo_serial_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_tx_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter: the controller
// state encoding and the level the serial line rests at between frames.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clock cycles per serial bit and
// flags the last cycle of each bit so the controller knows when to advance.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart_i,
  output logic          bit_tick_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign bit_tick_o = (cnt_q == LAST);
  assign count_o    = cnt_q;

  // Cycle counter: cleared by reset or restart, otherwise wraps after the last cycle of a bit
  always_ff @(posedge clk) begin
    if (rst || restart_i) begin
      cnt_q <= '0;
    end else if (bit_tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO-reader serial transmitter. Pops one word at a time from a synchronous
// FIFO and sends it as start bit, N data bits LSB first, optional even parity
// bit and stop bit. Define TX_PARITY_EN to include the parity bit.
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int N            = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_en,
  input  logic         fifo_empty,
  input  logic [N-1:0] fifo_data,
  output logic         fifo_rd_en,
  output logic         tx,
  output logic         busy,
  output logic         word_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(N + 1);
  localparam bit SINGLE_CLK = (CLKS_PER_BIT == 1);
  localparam logic [CW-1:0] PRELAST = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [BW-1:0] LASTBIT = BW'(N - 1);

  tx_state_e     state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic          tx_q, tx_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic          bitTick;
  logic [CW-1:0] bitCount;
  logic          timerRestart;

  // The bit clock is held at zero until the frame proper begins, so START gets a full bit time
  assign timerRestart = (state_q == IDLE) || (state_q == READ) || (state_q == LOAD);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .restart_i (timerRestart),
    .bit_tick_o(bitTick),
    .count_o   (bitCount)
  );

  assign fifo_rd_en = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign word_done  = done_q;

  // Next-state and next-output logic; outputs are computed one cycle ahead so they leave registered
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    rd_d     = 1'b0;
    done_d   = 1'b0;
`ifdef TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (tx_en && !fifo_empty) begin
          state_d = READ;
          rd_d    = 1'b1;
        end
      end
      READ: begin
        state_d = LOAD;
      end
      LOAD: begin
        // The FIFO only presents real data in the cycle after the pop, so capture happens here alone
        shift_d  = fifo_data;
        bitcnt_d = '0;
        tx_d     = 1'b0;
        state_d  = START;
`ifdef TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
      end
      START: begin
        if (bitTick) begin
          state_d  = DATA;
          tx_d     = shift_q[0];
          shift_d  = shift_q >> 1;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (bitTick) begin
          if (bitcnt_q == LASTBIT) begin
`ifdef TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = IDLE_LEVEL;
            if (SINGLE_CLK) done_d = 1'b1;
`endif
          end else begin
            tx_d     = shift_q[0];
            shift_d  = shift_q >> 1;
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (bitTick) begin
          state_d = STOP;
          tx_d    = IDLE_LEVEL;
          if (SINGLE_CLK) done_d = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = IDLE_LEVEL;
        if (bitTick) begin
          if (tx_en && !fifo_empty) begin
            state_d = READ;
            rd_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!SINGLE_CLK && (bitCount == PRELAST)) begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset; a reset abandons any word in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      tx_q     <= IDLE_LEVEL;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Self-checking bench for fifo_serial_tx. A small array-based FIFO model feeds
// the DUT; each frame is compared against a bit list built from the word.
// Honours TX_PARITY_EN the same way the design does.
module tb_fifo_serial_tx;

  localparam int NW   = 4;
  localparam int CLKS = 4;
`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = NW + 2 + PAR;
  localparam int FRAME_LEN  = FRAME_BITS * CLKS;

  logic          clk = 1'b0;
  logic          rst;
  logic          txEn;
  logic          fifoEmpty;
  logic [NW-1:0] fifoData = '0;
  logic          fifoRdEn;
  logic          tx;
  logic          busy;
  logic          wordDone;

  logic [NW-1:0] fifoMem [0:63];
  int            wrPtr = 0;
  int            rdPtr = 0;

  int checkCount = 0;
  int passCount  = 0;
  int cycleNo    = 0;
  int rdPulses   = 0;
  int rdViol     = 0;
  int lastRdCycle = 0;
  int prevFrameEnd = 0;
  bit prevRd = 1'b0;

  fifo_serial_tx #(
    .N(NW),
    .CLKS_PER_BIT(CLKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (txEn),
    .fifo_empty(fifoEmpty),
    .fifo_data (fifoData),
    .fifo_rd_en(fifoRdEn),
    .tx        (tx),
    .busy      (busy),
    .word_done (wordDone)
  );

  always #5 clk = ~clk;

  assign fifoEmpty = (wrPtr == rdPtr);

  // FIFO read port model: data appears in the cycle after a pop and is zero otherwise
  always @(posedge clk) begin
    if (fifoRdEn && (rdPtr != wrPtr)) begin
      fifoData <= fifoMem[rdPtr[5:0]];
      rdPtr    <= rdPtr + 1;
    end else begin
      fifoData <= '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic pushWord(input logic [NW-1:0] w);
    fifoMem[wrPtr[5:0]] = w;
    wrPtr = wrPtr + 1;
  endtask

  // Advance to the next falling edge and keep the pop-request bookkeeping
  task automatic tick();
    @(negedge clk);
    cycleNo++;
    if (fifoRdEn === 1'b1) begin
      rdPulses++;
      lastRdCycle = cycleNo;
      if (prevRd) rdViol++;
      if (fifoEmpty) rdViol++;
    end
    prevRd = (fifoRdEn === 1'b1);
  endtask

  task automatic waitFrameStart(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Watch one whole frame, compare each bit time against the expected level list
  task automatic applyStimulus(input logic [NW-1:0] word, input string tag, input bit checkGap, input int dropAt);
    bit ok;
    logic levels [0:FRAME_BITS-1];
    logic [CLKS-1:0] obs;
    int wdCount;
    int wdIdx;
    int busyLow;
    int idx;
    levels[0] = 1'b0;
    for (int i = 0; i < NW; i++) levels[i+1] = word[i];
`ifdef TX_PARITY_EN
    levels[NW+1] = ^word;
`endif
    levels[FRAME_BITS-1] = 1'b1;
    waitFrameStart(ok);
    checkOutput($sformatf("%s_start_seen", tag), {31'd0, ok}, 32'd1);
    if (!ok) return;
    checkOutput($sformatf("%s_latency", tag), cycleNo - lastRdCycle, 32'd2);
    if (checkGap) checkOutput($sformatf("%s_gap", tag), cycleNo - prevFrameEnd - 1, 32'd2);
    wdCount = 0;
    wdIdx   = -1;
    busyLow = 0;
    idx     = 0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      obs = '0;
      for (int c = 0; c < CLKS; c++) begin
        if (b != 0 || c != 0) tick();
        obs[c] = tx;
        if (wordDone === 1'b1) begin
          wdCount++;
          wdIdx = idx;
        end
        if (busy !== 1'b1) busyLow++;
        if (idx == dropAt) txEn = 1'b0;
        idx++;
      end
      checkOutput($sformatf("%s_bit%0d", tag, b), obs, {CLKS{levels[b]}});
    end
    checkOutput($sformatf("%s_done_count", tag), wdCount, 32'd1);
    checkOutput($sformatf("%s_done_pos", tag), wdIdx, FRAME_LEN - 1);
    checkOutput($sformatf("%s_busy", tag), busyLow, 32'd0);
    prevFrameEnd = cycleNo;
  endtask

  // Watch the line for a quiet stretch and confirm nothing was popped or sent
  task automatic checkQuiet(input string tag, input int cycles);
    int pops0;
    int txLow;
    int busyHigh;
    pops0    = rdPulses;
    txLow    = 0;
    busyHigh = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (tx !== 1'b1) txLow++;
      if (busy !== 1'b0) busyHigh++;
    end
    checkOutput($sformatf("%s_no_pop", tag), rdPulses - pops0, 32'd0);
    checkOutput($sformatf("%s_tx_idle", tag), txLow, 32'd0);
    checkOutput($sformatf("%s_not_busy", tag), busyHigh, 32'd0);
  endtask

  // Directed steps followed by a randomized burst of back-to-back words
  initial begin
    logic [NW-1:0] wA;
    logic [NW-1:0] wB;
    logic [NW-1:0] rw [0:5];
    bit ok;
    int pops0;

    rst  = 1'b1;
    txEn = 1'b1;
    pushWord(4'hA);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("reset_cycle%0d", i), {28'd0, tx, busy, fifoRdEn, wordDone}, 32'h8);
    end
    rst = 1'b0;

    $display("[TB] single word 4'hA");
    applyStimulus(4'hA, "single", 1'b0, -1);
    tick();
    checkOutput("single_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("single_pops", rdPulses, 32'd1);

    $display("[TB] back-to-back 4'h3, 4'hC");
    pushWord(4'h3);
    pushWord(4'hC);
    applyStimulus(4'h3, "b2b0", 1'b0, -1);
    applyStimulus(4'hC, "b2b1", 1'b1, -1);
    tick();
    checkOutput("b2b_pops", rdPulses, 32'd3);

`ifdef TX_PARITY_EN
    $display("[TB] parity word 4'h7");
    pushWord(4'h7);
    applyStimulus(4'h7, "parity", 1'b0, -1);
    tick();
`endif

    $display("[TB] empty and disabled");
    checkQuiet("empty", 50);
    txEn = 1'b0;
    wA = NW'($urandom_range(0, 15));
    pushWord(wA);
    checkQuiet("disabled", 20);

    $display("[TB] tx_en drop mid-frame");
    wB = NW'($urandom_range(0, 15));
    pushWord(wB);
    txEn = 1'b1;
    applyStimulus(wA, "drop", 1'b0, 8);
    checkQuiet("after_drop", 30);
    checkOutput("after_drop_left", wrPtr - rdPtr, 32'd1);

    $display("[TB] reset mid-frame");
    txEn = 1'b1;
    waitFrameStart(ok);
    checkOutput("rst_frame_seen", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_frame", {30'd0, tx, busy}, 32'h2);
    rst = 1'b0;
    pops0 = rdPulses;
    checkQuiet("after_rst", 20);
    checkOutput("after_rst_empty", wrPtr - rdPtr, 32'd0);
    checkOutput("after_rst_pops", rdPulses - pops0, 32'd0);

    $display("[TB] random back-to-back burst");
    for (int i = 0; i < 6; i++) begin
      rw[i] = NW'($urandom_range(0, 15));
      pushWord(rw[i]);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(rw[i], $sformatf("rand%0d", i), (i > 0), -1);
    end
    checkQuiet("final", 10);

    checkOutput("rd_en_rules", rdViol, 32'd0);
    checkOutput("total_pops", rdPulses, wrPtr);
    checkOutput("fifo_drained", wrPtr - rdPtr, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
